i2s_tdm_tx: RTL and testbench

Downstream consumer of the UART channel receiver. Takes a 32-channel × 8-bit snapshot over a ready/acknowledge handshake. Serializes it as a continuous TDM frame (BCLK, frame sync, serial data) toward the stimulation DAC/codec. Frames repeat back-to-back. A new snapshot is taken only at frame boundaries, so no frame ever mixes old and new data.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_bclk_gen.sv | 46 ++++
 rtl/i2s_tdm_tx.sv | 178 +++++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults, frame payload type and FSM state encoding
// for the TDM serial transmitter.
package i2s_pkg;

    localparam int unsigned NUM_CH_DFLT     = 32;
    localparam int unsigned SLOT_WIDTH_DFLT = 8;

    // One snapshot: frame[ch][bit], channel 0 is transmitted first
    typedef logic [NUM_CH_DFLT-1:0][SLOT_WIDTH_DFLT-1:0] chan_frame_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into the TDM bit clock.
//   clk, rst_n   : system clock, async active-low reset
//   en           : run; low holds the divider cleared with bclk low
//   clr          : synchronous clear, used on a load from idle
//   bclk         : registered bit clock, BCLK_DIV clks per half-period
//   bclk_fall_c  : strobe on the clk edge that takes bclk low
//   bclk_rise_c  : strobe on the clk edge that takes bclk high
module i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bclk,
    output logic bclk_fall_c,
    output logic bclk_rise_c
);

    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             wrap_c;

    assign wrap_c      = en && !clr && (div == DIV_MAX);
    assign bclk_fall_c = wrap_c && bclk;
    assign bclk_rise_c = wrap_c && !bclk;

    // Half-period counter; bclk toggles on each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (clr || !en) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (wrap_c) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div  <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: takes NUM_CH x SLOT_WIDTH snapshots over a 4-phase
// ready/acknowledge handshake and sends them as back-to-back TDM frames
// (bclk, fs, sdout MSB first). Snapshots are only taken at frame boundaries.
//   enable           : run request, stop takes effect at the frame boundary
//   in_channel_data  : channel bytes, data_ready/data_acknowledge handshake
//   bclk, fs, sdout  : serial interface toward the codec
//   frame_done       : one-clk pulse at each frame boundary
//   underrun         : one-clk pulse when a boundary finds no fresh data
// Build option: I2S_TX_MUTE_ON_UNDERRUN_EN clears the frame on underrun so
// silence is sent until the next load; otherwise the last frame repeats.
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_FRE    = 50,
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned NUM_CH     = NUM_CH_DFLT,
    parameter int unsigned SLOT_WIDTH = SLOT_WIDTH_DFLT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [NUM_CH-1:0][SLOT_WIDTH-1:0]    in_channel_data,
    input  logic                                 data_ready,
    output logic                                 data_acknowledge,
    output logic                                 bclk,
    output logic                                 fs,
    output logic                                 sdout,
    output logic                                 frame_done,
    output logic                                 underrun
);

    localparam int unsigned SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BIT_W  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
    localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(SLOT_WIDTH - 1);

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif

    // Reject divider settings that cannot produce a bit clock
    if (BCLK_DIV < 2 || CLK_FRE == 0) begin : g_bad_param
        $error("i2s_tdm_tx: BCLK_DIV must be >= 2 and CLK_FRE nonzero");
    end

    state_t state, next_state;

    logic [NUM_CH-1:0][SLOT_WIDTH-1:0] frame_buf;
    logic [SLOT_W-1:0] slot, adv_slot;
    logic [BIT_W-1:0]  bit_idx, adv_bit;

    logic bclk_fall_c, bclk_rise_c;
    logic boundary_c, load_c, start_c, advance_c, frame_done_c, underrun_c;

    assign start_c = load_c && (state == S_IDLE);

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (state == S_RUN),
        .clr         (start_c),
        .bclk        (bclk),
        .bclk_fall_c (bclk_fall_c),
        .bclk_rise_c (bclk_rise_c)
    );

    // Next-state and per-edge control decode
    always_comb begin
        next_state   = state;
        load_c       = 1'b0;
        advance_c    = 1'b0;
        frame_done_c = 1'b0;
        underrun_c   = 1'b0;
        boundary_c   = (state == S_RUN) && bclk_fall_c &&
                       (slot == LAST_SLOT) && (bit_idx == '0);
        if (bit_idx == '0) begin
            adv_bit  = TOP_BIT;
            adv_slot = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
        end else begin
            adv_bit  = bit_idx - BIT_W'(1);
            adv_slot = slot;
        end
        case (state)
            S_IDLE: begin
                if (enable && data_ready && !data_acknowledge) begin
                    load_c     = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (boundary_c) begin
                    frame_done_c = 1'b1;
                    // A falling enable beats a pending load
                    if (!enable) begin
                        next_state = S_IDLE;
                    end else if (data_ready && !data_acknowledge) begin
                        load_c = 1'b1;
                    end else begin
                        underrun_c = 1'b1;
                    end
                end else if (bclk_fall_c) begin
                    advance_c = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Serial outputs, pointers, handshake and event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot             <= '0;
            bit_idx          <= TOP_BIT;
            sdout            <= 1'b0;
            fs               <= 1'b0;
            data_acknowledge <= 1'b0;
            frame_done       <= 1'b0;
            underrun         <= 1'b0;
        end else begin
            frame_done <= frame_done_c;
            underrun   <= underrun_c;

            if (load_c) begin
                data_acknowledge <= 1'b1;
            end else if (!data_ready) begin
                data_acknowledge <= 1'b0;
            end

            if (load_c) begin
                // First bit comes straight from the incoming snapshot
                slot    <= '0;
                bit_idx <= TOP_BIT;
                sdout   <= in_channel_data[0][SLOT_WIDTH-1];
                fs      <= 1'b1;
            end else if (underrun_c) begin
                slot    <= '0;
                bit_idx <= TOP_BIT;
                sdout   <= MUTE_EN ? 1'b0 : frame_buf[0][SLOT_WIDTH-1];
                fs      <= 1'b1;
            end else if (advance_c) begin
                slot    <= adv_slot;
                bit_idx <= adv_bit;
                sdout   <= frame_buf[adv_slot][adv_bit];
                fs      <= 1'b0;
            end else if (next_state == S_IDLE) begin
                sdout   <= 1'b0;
                fs      <= 1'b0;
            end
        end
    end

    // Frame buffer; contents are irrelevant until the first load
    always_ff @(posedge clk) begin
        if (load_c) begin
            frame_buf <= in_channel_data;
        end else if (underrun_c && MUTE_EN) begin
            frame_buf <= '0;
        end
    end

    // The divider never reports both edges on the same clk
    a_edge_excl: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(bclk_rise_c && bclk_fall_c));

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: directed bench for i2s_tdm_tx at BCLK_DIV=4, 32x8 slots.
// A negedge monitor decodes frames on bclk rises; stimulus runs a fixed
// sequence of loads, underruns, a stop and a reset, then checks the
// captured frames and event times against hand-computed tables.
module tb_i2s_tdm_tx;
    import i2s_pkg::*;

    localparam int FRAME_CLKS = 2048;
    localparam int FRAME_BITS = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    chan_frame_t in_data;
    logic        data_ready;
    logic        data_acknowledge, bclk, fs, sdout, frame_done, underrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    i2s_tdm_tx #(
        .CLK_FRE    (50),
        .BCLK_DIV   (4),
        .NUM_CH     (32),
        .SLOT_WIDTH (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .in_channel_data  (in_data),
        .data_ready       (data_ready),
        .data_acknowledge (data_acknowledge),
        .bclk             (bclk),
        .fs               (fs),
        .sdout            (sdout),
        .frame_done       (frame_done),
        .underrun         (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    logic [FRAME_BITS-1:0] frames_q[$];
    int fstart_q[$];
    int fd_q[$];
    int ur_q[$];
    logic [FRAME_BITS-1:0] cur;
    int  cur_cnt = 0;
    int  cur_start = 0;
    bit  in_frame = 1'b0;
    int  fs_err = 0;
    int  rise_cnt = 0;
    int  loads = 0;
    logic bclk_q = 1'b0;
    logic ack_q = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            cur_cnt  = 0;
        end else begin
            if (bclk && !bclk_q) begin
                rise_cnt++;
                if (fs) begin
                    if (in_frame && cur_cnt != FRAME_BITS) fs_err++;
                    in_frame  = 1'b1;
                    cur_cnt   = 0;
                    cur_start = cyc;
                end
                if (!in_frame || cur_cnt >= FRAME_BITS) begin
                    fs_err++;
                end else begin
                    cur[cur_cnt] = sdout;
                    cur_cnt++;
                    if (cur_cnt == FRAME_BITS) begin
                        frames_q.push_back(cur);
                        fstart_q.push_back(cur_start);
                    end
                end
            end
            if (frame_done) fd_q.push_back(cyc);
            if (underrun) ur_q.push_back(cyc);
            if (data_acknowledge && !ack_q) loads++;
        end
        bclk_q = bclk;
        ack_q  = data_acknowledge;
    end

    // ---------------- helpers ----------------
    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bits(input string name, input logic [FRAME_BITS-1:0] act,
                              input logic [FRAME_BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transmit order: channel 0 first, MSB first
    function automatic logic [FRAME_BITS-1:0] stream_of(input chan_frame_t d);
        logic [FRAME_BITS-1:0] s;
        for (int k = 0; k < FRAME_BITS; k++) s[k] = d[k/8][7-(k%8)];
        return s;
    endfunction

    function automatic chan_frame_t fill(input bit ramp, input logic [7:0] b);
        chan_frame_t d;
        for (int i = 0; i < 32; i++) d[i] = ramp ? 8'(i) : b;
        return d;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_ack(input string name, input int limit, output int seen);
        seen = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (data_acknowledge) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) check_int({name, " ack timeout"}, 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_int({tag, " bclk"}, int'(bclk), 0);
        check_int({tag, " fs"}, int'(fs), 0);
        check_int({tag, " sdout"}, int'(sdout), 0);
        check_int({tag, " data_acknowledge"}, int'(data_acknowledge), 0);
        check_int({tag, " frame_done"}, int'(frame_done), 0);
        check_int({tag, " underrun"}, int'(underrun), 0);
    endtask

    // ---------------- expectation tables ----------------
    typedef struct {
        string       name;
        chan_frame_t data;
        int          start_off;
    } frame_exp_t;

    frame_exp_t fexp[6];
    int ur_exp[3];
    chan_frame_t replay_ramp, replay_55;

    // ---------------- stimulus ----------------
    initial begin
        int n0, seen, x, m, k, snap;

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
        replay_ramp = '0;
        replay_55   = '0;
`else
        replay_ramp = fill(1'b1, 8'h00);
        replay_55   = fill(1'b0, 8'h55);
`endif
        // Frames relative to the first load edge; first rise is 4 clks in
        fexp[0] = '{"frame1 ramp",        fill(1'b1, 8'h00), 4};
        fexp[1] = '{"frame2 underrun",    replay_ramp,       4 + 1*FRAME_CLKS};
        fexp[2] = '{"frame3 A3",          fill(1'b0, 8'hA3), 4 + 2*FRAME_CLKS};
        fexp[3] = '{"frame4 55 no gap",   fill(1'b0, 8'h55), 4 + 3*FRAME_CLKS};
        fexp[4] = '{"frame5 underrun",    replay_55,         4 + 4*FRAME_CLKS};
        fexp[5] = '{"frame6 underrun",    replay_55,         4 + 5*FRAME_CLKS};
        ur_exp  = '{1*FRAME_CLKS, 4*FRAME_CLKS, 5*FRAME_CLKS};

        rst_n = 1'b0; enable = 1'b0; data_ready = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Ready while disabled must not load
        in_data = fill(1'b1, 8'h00);
        data_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_int("disabled no ack", int'(data_acknowledge), 0);
        check_int("disabled bclk", int'(bclk), 0);

        // Load from idle on the first edge with the conditions true
        x = cyc;
        enable = 1'b1;
        wait_ack("frame1", 10, seen);
        check_int("load latency", seen - x, 1);
        n0 = seen;

        // Handshake: hold ready 10 clks, ack must stay, then drop 1 clk later
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_acknowledge) k++;
        end
        check_int("ack held during ready", k, 10);
        data_ready = 1'b0;
        @(negedge clk);
        check_int("ack drop after ready low", int'(data_acknowledge), 0);
        check_int("single load after handshake", loads, 1);

        // Mid-frame ready is held off to the boundary
        wait_until(n0 + FRAME_CLKS + 1000);
        in_data = fill(1'b0, 8'hA3);
        data_ready = 1'b1;
        wait_until(n0 + FRAME_CLKS + 1500);
        check_int("mid-frame ready held off", int'(data_acknowledge), 0);
        wait_ack("frame3", 1000, seen);
        check_int("frame3 load cycle", seen - n0, 2*FRAME_CLKS);
        repeat (2) @(negedge clk);
        data_ready = 1'b0;

        // Halfway through the A3 frame present 0x55
        wait_until(n0 + 2*FRAME_CLKS + 1024);
        in_data = fill(1'b0, 8'h55);
        data_ready = 1'b1;
        wait_ack("frame4", 2000, seen);
        check_int("frame4 load cycle", seen - n0, 3*FRAME_CLKS);
        repeat (2) @(negedge clk);
        data_ready = 1'b0;

        // During frame 6: pending data, then enable drops; stop must win
        wait_until(n0 + 5*FRAME_CLKS + 500);
        in_data = fill(1'b0, 8'h3C);
        data_ready = 1'b1;
        wait_until(n0 + 5*FRAME_CLKS + 1000);
        enable = 1'b0;
        wait_until(n0 + 6*FRAME_CLKS + 20);
        check_int("stop: no ack on boundary", int'(data_acknowledge), 0);
        check_int("stop: bclk low", int'(bclk), 0);
        check_int("stop: fs low", int'(fs), 0);
        check_int("stop: sdout low", int'(sdout), 0);
        snap = rise_cnt;
        repeat (100) @(negedge clk);
        check_int("stop: no bclk activity", rise_cnt - snap, 0);

        // Restart from idle; first bclk rise BCLK_DIV clks after the load
        x = cyc;
        enable = 1'b1;
        wait_ack("frame7", 10, seen);
        check_int("restart load latency", seen - x, 1);
        m = seen;
        k = 0;
        while (!bclk && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_int("first bclk rise delay", cyc - m, 4);

        // Reset mid-frame: outputs clear without waiting for a clk edge
        wait_until(m + 300);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-frame reset");
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        snap = rise_cnt;
        repeat (50) @(negedge clk);
        check_int("post-reset no bclk", rise_cnt - snap, 0);
        check_int("post-reset no ack", int'(data_acknowledge), 0);

        // Captured frames against the table
        check_int("frames captured", frames_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < frames_q.size()) begin
                check_bits(fexp[i].name, frames_q[i], stream_of(fexp[i].data));
                check_int({fexp[i].name, " start"}, fstart_q[i] - n0, fexp[i].start_off);
            end
        end
        check_int("fs placement errors", fs_err, 0);

        check_int("frame_done count", fd_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < fd_q.size())
                check_int($sformatf("frame_done %0d cycle", i), fd_q[i] - n0, (i + 1) * FRAME_CLKS);
        end
        check_int("underrun count", ur_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < ur_q.size())
                check_int($sformatf("underrun %0d cycle", i), ur_q[i] - n0, ur_exp[i]);
        end
        check_int("total loads", loads, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
